ovsf_spreader: RTL

- Downstream consumer of the OVSF channelisation code. Takes I/Q symbol bits through a valid/ready handshake and spreads each symbol over SF chips at the chip rate.
- Emits a registered I/Q chip stream toward the scrambler/modulator.
- Contains its own OVSF chip generator, so the chip index and the code stay locked to symbol boundaries.

---
 rtl/ovsf_spreader_pkg.sv | 32 +++
 rtl/ovsf_chip_gen.sv | 31 +++
 rtl/ovsf_spreader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ovsf_spreader_pkg.sv
// Shared OVSF types, spreading-factor codes and length helpers for the
// spreader and despreader.
package ovsf_spreader_pkg;

  localparam int unsigned SF_W  = 3;
  localparam int unsigned K_W   = 9;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned LEN_W = 10;

  localparam logic [SF_W-1:0] SF4   = 3'd0;
  localparam logic [SF_W-1:0] SF8   = 3'd1;
  localparam logic [SF_W-1:0] SF16  = 3'd2;
  localparam logic [SF_W-1:0] SF32  = 3'd3;
  localparam logic [SF_W-1:0] SF64  = 3'd4;
  localparam logic [SF_W-1:0] SF128 = 3'd5;
  localparam logic [SF_W-1:0] SF256 = 3'd6;
  localparam logic [SF_W-1:0] SF512 = 3'd7;

  typedef struct packed {
    logic i;
    logic q;
  } sym_iq_t;

  function automatic logic [LEN_W-1:0] sf_len(input logic [SF_W-1:0] sf);
    return LEN_W'(4) << sf;
  endfunction

  function automatic logic [CNT_W-1:0] sf_mask(input logic [SF_W-1:0] sf);
    return CNT_W'(sf_len(sf) - LEN_W'(1));
  endfunction

endpackage

// File: rtl/ovsf_chip_gen.sv
// Combinational OVSF code bit: parity of (bit-reversed code number & chip index),
// reversal taken over log2(SF) bits.
module ovsf_chip_gen
  import ovsf_spreader_pkg::*;
(
  input  logic [SF_W-1:0]  i_sf_l,
  input  logic [K_W-1:0]   i_k_l,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_code
);

  logic [CNT_W-1:0] w_mask;
  logic [K_W-1:0]   w_kmask;
  logic [K_W-1:0]   w_rev9;
  logic [K_W-1:0]   w_krev;
  logic [3:0]       w_shift;

  // Full-width reverse then shift down by (K_W - log2(SF)) gives an L-bit reverse.
  always_comb begin
    w_mask  = sf_mask(i_sf_l);
    w_kmask = i_k_l & K_W'(w_mask);
    w_rev9  = '0;
    for (int j = 0; j < int'(K_W); j++) begin
      w_rev9[j] = w_kmask[int'(K_W) - 1 - j];
    end
    w_shift = 4'(K_W - 2) - 4'(i_sf_l);
    w_krev  = w_rev9 >> w_shift;
    o_code  = ^(w_krev & K_W'(i_cnt) & K_W'(w_mask));
  end

endmodule

// File: rtl/ovsf_spreader.sv
// OVSF spreader: one-deep symbol buffer, chip-rate spreading over SF chips.
// Optional saturating underrun counter on port ucnt when OVSF_SPREADER_UCNT_EN is defined.
module ovsf_spreader
  import ovsf_spreader_pkg::*;
#(
  parameter int unsigned UCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chip_en,
  input  logic [SF_W-1:0]   sf,
  input  logic [K_W-1:0]    code_k,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              sym_i,
  input  logic              sym_q,
  output logic              chip_valid,
  output logic              chip_i,
  output logic              chip_q,
  output logic              sym_start,
  output logic              underrun
`ifdef OVSF_SPREADER_UCNT_EN
  ,
  output logic [UCNT_W-1:0] ucnt
`endif
);

  typedef enum logic {IDLE, SPREAD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  sym_iq_t          r_pend;
  sym_iq_t          r_cur;
  logic             r_pend_full;
  logic             r_sym_ready;
  logic [SF_W-1:0]  r_sf_l;
  logic [K_W-1:0]   r_k_l;
  logic             r_chip_valid;
  logic             r_chip_i;
  logic             r_chip_q;
  logic             r_sym_start;
  logic             r_underrun;
`ifdef OVSF_SPREADER_UCNT_EN
  logic [UCNT_W-1:0] r_ucnt;
`else
  logic             w_unused_ucnt_w;
  assign w_unused_ucnt_w = |32'(UCNT_W);
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_pend_full_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_code;

  ovsf_chip_gen u_chip_gen (
    .i_sf_l (r_sf_l),
    .i_k_l  (r_k_l),
    .i_cnt  (w_cnt_nxt),
    .o_code (w_code)
  );

  // Load happens from IDLE or on the last chip, whenever a symbol is pending.
  always_comb begin
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_accept        = sym_valid && r_sym_ready;
    w_last          = (r_cnt == sf_mask(r_sf_l));
    w_load          = chip_en && r_pend_full && ((r_state == IDLE) || w_last);
    w_pend_full_nxt = w_accept || (r_pend_full && !w_load);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pend       <= '0;
      r_cur        <= '0;
      r_pend_full  <= 1'b0;
      r_sym_ready  <= 1'b1;
      r_sf_l       <= '0;
      r_k_l        <= '0;
      r_chip_valid <= 1'b0;
      r_chip_i     <= 1'b0;
      r_chip_q     <= 1'b0;
      r_sym_start  <= 1'b0;
      r_underrun   <= 1'b0;
`ifdef OVSF_SPREADER_UCNT_EN
      r_ucnt       <= '0;
`endif
    end else begin
      r_chip_valid <= 1'b0;
      r_sym_start  <= 1'b0;
      r_underrun   <= 1'b0;
      r_pend_full  <= w_pend_full_nxt;
      r_sym_ready  <= !w_pend_full_nxt;
      if (w_accept) begin
        r_pend <= '{i: sym_i, q: sym_q};
      end
      // Chip 0 always carries code bit 0, so the symbol bits go straight out.
      if (w_load) begin
        r_cur        <= r_pend;
        r_sf_l       <= sf;
        r_k_l        <= code_k;
        r_cnt        <= '0;
        r_chip_i     <= r_pend.i;
        r_chip_q     <= r_pend.q;
        r_chip_valid <= 1'b1;
        r_sym_start  <= 1'b1;
        r_state      <= SPREAD;
      end else if (chip_en && (r_state == SPREAD)) begin
        if (!w_last) begin
          r_cnt        <= w_cnt_nxt;
          r_chip_i     <= r_cur.i ^ w_code;
          r_chip_q     <= r_cur.q ^ w_code;
          r_chip_valid <= 1'b1;
        end else begin
          r_underrun <= 1'b1;
          r_state    <= IDLE;
`ifdef OVSF_SPREADER_UCNT_EN
          if (r_ucnt != '1) begin
            r_ucnt <= r_ucnt + UCNT_W'(1);
          end
`endif
        end
      end
    end
  end

  assign sym_ready  = r_sym_ready;
  assign chip_valid = r_chip_valid;
  assign chip_i     = r_chip_i;
  assign chip_q     = r_chip_q;
  assign sym_start  = r_sym_start;
  assign underrun   = r_underrun;
`ifdef OVSF_SPREADER_UCNT_EN
  assign ucnt       = r_ucnt;
`endif

endmodule
